enemy_hp_ctrl: RTL and testbench
================================

// Module: enemy_hp_ctrl
// PURPOSE
//  Per-slot hit-point and explosion controller feeding enemy_base's disappear_i.
//  Takes slot spawn events (trigger/trigger_idx from enemy_base) and bullet-hit events
//  (from the collision detector, already in clk_run domain). Runs a per-slot ALIVE/EXPLODE
//  lifecycle and pulses disappear_o[i] when an explosion finishes. Keeps the kill score.
// PARAMETERS
//  MAX_ENEMY_NUM          10  number of enemy slots; must match enemy_base
//  MAX_ENEMY_NUM_BIT_LEN  4   width of slot index
//  ENEMY_HP               3   hits needed to kill (>=1)
//  HP_BIT_LEN             2   width of HP counter (holds ENEMY_HP)
//  EXPLODE_FRAMES         8   frames the explosion lasts before disappear (>=1)
//  EXPLODE_BIT_LEN        4   width of explosion frame counter (holds EXPLODE_FRAMES)
//  SCORE_PER_KILL         1   score added per kill
//  SCORE_BIT_LEN          16  score width
// PORTS
//  clk_run         in   1                      game-logic clock
//  rst             in   1                      reset, asynchronous, active-high
//  en_i            in   1                      1 = run; 0 = freeze all state, no pulses
//  trigger_i       in   1                      one-cycle spawn pulse from enemy_base
//  trigger_idx_i   in   MAX_ENEMY_NUM_BIT_LEN  slot being spawned
//  hit_i           in   1                      one-cycle bullet-hit pulse
//  hit_idx_i       in   MAX_ENEMY_NUM_BIT_LEN  slot hit
//  frame_tick_i    in   1                      one-cycle pulse per video frame (clk_run domain)
//  score_clr_i     in   1                      synchronous score clear
//  disappear_o     out  MAX_ENEMY_NUM          one-cycle pulse per slot -> enemy_base disappear_i
//  exploding_o     out  MAX_ENEMY_NUM          level: slot is in EXPLODE (sprite select)
//  kill_o          out  1                      one-cycle pulse on any kill
//  score_o         out  SCORE_BIT_LEN          accumulated score
// BEHAVIOUR
//  - Per-slot state IDLE/ALIVE/EXPLODE, hp, explode cnt. Reset: all IDLE, hp=0, cnt=0,
//    all outputs 0. All outputs registered; every response appears one clk_run after cause.
//  - en_i=0: every register holds; disappear_o, kill_o forced 0; inputs that cycle are lost.
//  - trigger_i for slot i (any state): -> ALIVE, hp=ENEMY_HP, cnt=0, no disappear pulse
//    (covers enemy leaving screen bottom, incl. mid-explosion).
//  - hit_i for slot i in ALIVE: hp>1 -> hp-1; hp==1 -> EXPLODE, cnt=0, kill_o=1,
//    score += SCORE_PER_KILL saturating at all-ones. Hit in IDLE/EXPLODE ignored.
//  - EXPLODE + frame_tick_i: cnt==EXPLODE_FRAMES-1 -> disappear_o[i]=1 one cycle, -> IDLE,
//    cnt=0; else cnt+1. Explosion spans EXPLODE_FRAMES ticks counted from the tick after kill.
//  - Simultaneous trigger and hit, same slot: trigger wins, hit dropped. Different slots: both act.
//  - Kill and frame_tick same cycle: tick not counted for the new explosion.
//  - score_clr_i has priority over a same-cycle kill increment (score=0, kill_o still pulses).
//  - Index >= MAX_ENEMY_NUM on trigger_idx_i/hit_idx_i: ignored.
//  - rst mid-explosion: immediate IDLE, no disappear pulse.
// TESTING
//  1 trigger idx2; 3 hits idx2 -> hp 3,2,1,0; kill_o once on 3rd hit; score_o=1; exploding_o[2]=1.
//  2 After 1: 8 frame_ticks -> disappear_o[2] pulses 1 cycle after 8th tick; exploding_o[2]=0.
//  3 Hit idx5 while IDLE; hit idx2 while EXPLODE -> no hp change, no kill_o, score unchanged.
//  4 Same-cycle trigger idx4 + hit idx4 on ALIVE hp=1 slot -> hp=3, ALIVE, no kill_o.
//  5 en_i=0 during explosion over 5 ticks -> cnt frozen; resume; disappear after 8 counted ticks.
//  6 score preset all-ones -> kill keeps all-ones; score_clr_i with kill -> score_o=0, kill_o=1.

Source files
------------

// File: rtl/enemy_hp_ctrl.sv
// Per-slot hit-point and explosion controller.
// Tracks the IDLE/ALIVE/EXPLODE lifecycle of every enemy slot, counts the
// explosion frames, pulses disappear_o when an explosion finishes and keeps a
// saturating kill score.
module enemy_hp_ctrl #(
   parameter int unsigned MAX_ENEMY_NUM         = 10,
   parameter int unsigned MAX_ENEMY_NUM_BIT_LEN = 4,
   parameter int unsigned ENEMY_HP              = 3,
   parameter int unsigned HP_BIT_LEN            = 2,
   parameter int unsigned EXPLODE_FRAMES        = 8,
   parameter int unsigned EXPLODE_BIT_LEN       = 4,
   parameter int unsigned SCORE_PER_KILL        = 1,
   parameter int unsigned SCORE_BIT_LEN         = 16
) (
   input  logic                             clk_run,
   input  logic                             rst,
   input  logic                             en_i,
   input  logic                             trigger_i,
   input  logic [MAX_ENEMY_NUM_BIT_LEN-1:0] trigger_idx_i,
   input  logic                             hit_i,
   input  logic [MAX_ENEMY_NUM_BIT_LEN-1:0] hit_idx_i,
   input  logic                             frame_tick_i,
   input  logic                             score_clr_i,
   output logic [MAX_ENEMY_NUM-1:0]         disappear_o,
   output logic [MAX_ENEMY_NUM-1:0]         exploding_o,
   output logic                             kill_o,
   output logic [SCORE_BIT_LEN-1:0]         score_o
);

   localparam int unsigned SUM_W = SCORE_BIT_LEN + 1;

   localparam logic [HP_BIT_LEN-1:0]      HP_FULL   = HP_BIT_LEN'(ENEMY_HP);
   localparam logic [HP_BIT_LEN-1:0]      HP_ONE    = HP_BIT_LEN'(1);
   localparam logic [EXPLODE_BIT_LEN-1:0] CNT_LAST  = EXPLODE_BIT_LEN'(EXPLODE_FRAMES - 1);
   localparam logic [EXPLODE_BIT_LEN-1:0] CNT_ONE   = EXPLODE_BIT_LEN'(1);
   localparam logic [SUM_W-1:0]           SCORE_INC = SUM_W'(SCORE_PER_KILL);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ALIVE   = 2'd1,
      EXPLODE = 2'd2
   } slot_state_t;

   // Registered per-slot state
   slot_state_t                state_q [MAX_ENEMY_NUM];
   logic [HP_BIT_LEN-1:0]      hp_q    [MAX_ENEMY_NUM];
   logic [EXPLODE_BIT_LEN-1:0] cnt_q   [MAX_ENEMY_NUM];

   // Next-state values
   slot_state_t                state_nxt [MAX_ENEMY_NUM];
   logic [HP_BIT_LEN-1:0]      hp_nxt    [MAX_ENEMY_NUM];
   logic [EXPLODE_BIT_LEN-1:0] cnt_nxt   [MAX_ENEMY_NUM];

   logic [MAX_ENEMY_NUM-1:0]   disappear_nxt;
   logic [MAX_ENEMY_NUM-1:0]   exploding_nxt;
   logic                       kill_nxt;
   logic [SCORE_BIT_LEN-1:0]   score_nxt;
   logic [SUM_W-1:0]           score_sum;

   // Per-slot lifecycle: spawn beats a same-slot hit, hits only count while
   // alive, explosion frames only advance on frame ticks while exploding.
   always_comb begin
      disappear_nxt = '0;
      kill_nxt      = 1'b0;
      for (int i = 0; i < int'(MAX_ENEMY_NUM); i++) begin
         state_nxt[i] = state_q[i];
         hp_nxt[i]    = hp_q[i];
         cnt_nxt[i]   = cnt_q[i];
      end

      if (en_i) begin
         for (int i = 0; i < int'(MAX_ENEMY_NUM); i++) begin
            if (trigger_i && (trigger_idx_i == MAX_ENEMY_NUM_BIT_LEN'(i))) begin
               state_nxt[i] = ALIVE;
               hp_nxt[i]    = HP_FULL;
               cnt_nxt[i]   = '0;
            end else begin
               unique case (state_q[i])
                  ALIVE: begin
                     if (hit_i && (hit_idx_i == MAX_ENEMY_NUM_BIT_LEN'(i))) begin
                        if (hp_q[i] > HP_ONE) begin
                           hp_nxt[i] = hp_q[i] - HP_ONE;
                        end else begin
                           hp_nxt[i]    = '0;
                           state_nxt[i] = EXPLODE;
                           cnt_nxt[i]   = '0;
                           kill_nxt     = 1'b1;
                        end
                     end
                  end
                  EXPLODE: begin
                     if (frame_tick_i) begin
                        if (cnt_q[i] == CNT_LAST) begin
                           state_nxt[i]     = IDLE;
                           cnt_nxt[i]       = '0;
                           disappear_nxt[i] = 1'b1;
                        end else begin
                           cnt_nxt[i] = cnt_q[i] + CNT_ONE;
                        end
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

   // Sprite select follows the next slot state so it lines up with the state flop
   always_comb begin
      exploding_nxt = '0;
      for (int i = 0; i < int'(MAX_ENEMY_NUM); i++) begin
         exploding_nxt[i] = (state_nxt[i] == EXPLODE);
      end
   end

   // Score: clear wins over a same-cycle kill; increment saturates at all-ones
   always_comb begin
      score_nxt = score_o;
      score_sum = {1'b0, score_o} + SCORE_INC;
      if (en_i) begin
         if (score_clr_i) begin
            score_nxt = '0;
         end else if (kill_nxt) begin
            if (score_sum[SCORE_BIT_LEN]) begin
               score_nxt = '1;
            end else begin
               score_nxt = score_sum[SCORE_BIT_LEN-1:0];
            end
         end
      end
   end

   // Slot state registers; reset drops every slot to IDLE without a disappear pulse
   always_ff @(posedge clk_run or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(MAX_ENEMY_NUM); i++) begin
            state_q[i] <= IDLE;
            hp_q[i]    <= '0;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < int'(MAX_ENEMY_NUM); i++) begin
            state_q[i] <= state_nxt[i];
            hp_q[i]    <= hp_nxt[i];
            cnt_q[i]   <= cnt_nxt[i];
         end
      end
   end

   // Output registers
   always_ff @(posedge clk_run or posedge rst) begin
      if (rst) begin
         disappear_o <= '0;
         exploding_o <= '0;
         kill_o      <= 1'b0;
         score_o     <= '0;
      end else begin
         disappear_o <= disappear_nxt;
         exploding_o <= exploding_nxt;
         kill_o      <= kill_nxt;
         score_o     <= score_nxt;
      end
   end

endmodule

// File: tb/tb_enemy_hp_ctrl.sv
// Directed bench for enemy_hp_ctrl. Score width is reduced to 4 bits so the
// saturation point is reachable in a short run.
module tb_enemy_hp_ctrl;

   localparam int unsigned N  = 10;
   localparam int unsigned IW = 4;
   localparam int unsigned SW = 4;

   logic          clk_run = 1'b0;
   logic          rst;
   logic          en_i;
   logic          trigger_i;
   logic [IW-1:0] trigger_idx_i;
   logic          hit_i;
   logic [IW-1:0] hit_idx_i;
   logic          frame_tick_i;
   logic          score_clr_i;
   logic [N-1:0]  disappear_o;
   logic [N-1:0]  exploding_o;
   logic          kill_o;
   logic [SW-1:0] score_o;

   int n_cmp = 0;
   int n_bad = 0;

   enemy_hp_ctrl #(
      .MAX_ENEMY_NUM(N),
      .MAX_ENEMY_NUM_BIT_LEN(IW),
      .ENEMY_HP(3),
      .HP_BIT_LEN(2),
      .EXPLODE_FRAMES(8),
      .EXPLODE_BIT_LEN(4),
      .SCORE_PER_KILL(1),
      .SCORE_BIT_LEN(SW)
   ) dut (
      .clk_run(clk_run),
      .rst(rst),
      .en_i(en_i),
      .trigger_i(trigger_i),
      .trigger_idx_i(trigger_idx_i),
      .hit_i(hit_i),
      .hit_idx_i(hit_idx_i),
      .frame_tick_i(frame_tick_i),
      .score_clr_i(score_clr_i),
      .disappear_o(disappear_o),
      .exploding_o(exploding_o),
      .kill_o(kill_o),
      .score_o(score_o)
   );

   always #5 clk_run = ~clk_run;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of stimulus, then sample 1 ns after the edge
   task automatic drive(input logic tv, input int ti, input logic hv, input int hi,
                        input logic fv, input logic cv);
      trigger_i     = tv;
      trigger_idx_i = IW'(ti);
      hit_i         = hv;
      hit_idx_i     = IW'(hi);
      frame_tick_i  = fv;
      score_clr_i   = cv;
      @(posedge clk_run);
      #1;
      trigger_i     = 1'b0;
      hit_i         = 1'b0;
      frame_tick_i  = 1'b0;
      score_clr_i   = 1'b0;
   endtask

   task automatic trig(input int idx);
      drive(1'b1, idx, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic hit(input int idx);
      drive(1'b0, 0, 1'b1, idx, 1'b0, 1'b0);
   endtask

   task automatic tick();
      drive(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
   endtask

   task automatic idle();
      drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   // Spawn a slot and kill it; last hit optionally carries a score clear
   task automatic kill_slot(input int idx, input logic clr);
      trig(idx);
      hit(idx);
      hit(idx);
      drive(1'b0, 0, 1'b1, idx, 1'b0, clr);
   endtask

   initial begin
      rst           = 1'b1;
      en_i          = 1'b1;
      trigger_i     = 1'b0;
      trigger_idx_i = '0;
      hit_i         = 1'b0;
      hit_idx_i     = '0;
      frame_tick_i  = 1'b0;
      score_clr_i   = 1'b0;
      repeat (2) @(posedge clk_run);
      #1;
      chk("rst_disappear", 32'(disappear_o), 32'h0);
      chk("rst_exploding", 32'(exploding_o), 32'h0);
      chk("rst_kill",      32'(kill_o),      32'h0);
      chk("rst_score",     32'(score_o),     32'h0);
      rst = 1'b0;

      // Spawn slot 2 and take it through three hits
      trig(2);
      chk("t1_spawn_expl", 32'(exploding_o), 32'h0);
      hit(2);
      chk("t1_hit1_kill", 32'(kill_o), 32'h0);
      hit(2);
      chk("t1_hit2_kill", 32'(kill_o), 32'h0);
      hit(2);
      chk("t1_hit3_kill",  32'(kill_o),      32'h1);
      chk("t1_hit3_score", 32'(score_o),     32'h1);
      chk("t1_hit3_expl",  32'(exploding_o), 32'h004);
      idle();
      chk("t1_kill_pulse", 32'(kill_o), 32'h0);

      // Hits on an IDLE slot and on an exploding slot are ignored
      hit(5);
      chk("t3_idle_kill",  32'(kill_o),  32'h0);
      chk("t3_idle_score", 32'(score_o), 32'h1);
      hit(2);
      chk("t3_expl_kill",  32'(kill_o),      32'h0);
      chk("t3_expl_score", 32'(score_o),     32'h1);
      chk("t3_expl_expl",  32'(exploding_o), 32'h004);

      // Eight frame ticks end the explosion
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("t2_tick%0d_disp", k), 32'(disappear_o), 32'h0);
      end
      tick();
      chk("t2_tick8_disp", 32'(disappear_o), 32'h004);
      chk("t2_tick8_expl", 32'(exploding_o), 32'h0);
      idle();
      chk("t2_disp_pulse", 32'(disappear_o), 32'h0);

      // Out-of-range indices are ignored
      trig(12);
      hit(12);
      hit(12);
      hit(12);
      chk("oor_kill",  32'(kill_o),  32'h0);
      chk("oor_score", 32'(score_o), 32'h1);

      // Trigger and hit on the same slot: trigger wins and restores full HP
      trig(4);
      hit(4);
      hit(4);
      drive(1'b1, 4, 1'b1, 4, 1'b0, 1'b0);
      chk("t4_same_kill", 32'(kill_o),      32'h0);
      chk("t4_same_expl", 32'(exploding_o), 32'h0);
      hit(4);
      hit(4);
      chk("t4_hp_left", 32'(kill_o), 32'h0);
      hit(4);
      chk("t4_kill",  32'(kill_o),      32'h1);
      chk("t4_score", 32'(score_o),     32'h2);
      chk("t4_expl",  32'(exploding_o), 32'h010);

      // Freezing with en_i=0 mid-explosion does not count ticks
      tick();
      tick();
      tick();
      en_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         drive(1'b0, 0, 1'b1, 5, 1'b1, 1'b0);
         chk($sformatf("t5_frz%0d_disp", k), 32'(disappear_o), 32'h0);
         chk($sformatf("t5_frz%0d_expl", k), 32'(exploding_o), 32'h010);
      end
      en_i = 1'b1;
      for (int k = 4; k <= 7; k++) begin
         tick();
         chk($sformatf("t5_tick%0d_disp", k), 32'(disappear_o), 32'h0);
      end
      tick();
      chk("t5_tick8_disp", 32'(disappear_o), 32'h010);
      chk("t5_tick8_expl", 32'(exploding_o), 32'h0);

      // Trigger and hit on different slots both act; kill coincides with a tick
      trig(6);
      drive(1'b1, 3, 1'b1, 6, 1'b0, 1'b0);
      hit(6);
      drive(1'b0, 0, 1'b1, 6, 1'b1, 1'b0);
      chk("kt_kill",  32'(kill_o),      32'h1);
      chk("kt_score", 32'(score_o),     32'h3);
      chk("kt_expl",  32'(exploding_o), 32'h040);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("kt_tick%0d_disp", k), 32'(disappear_o), 32'h0);
      end
      tick();
      chk("kt_tick8_disp", 32'(disappear_o), 32'h040);
      hit(3);
      hit(3);
      hit(3);
      chk("diff_slot3_kill",  32'(kill_o),  32'h1);
      chk("diff_slot3_score", 32'(score_o), 32'h4);

      // Drive the 4-bit score to saturation
      for (int k = 0; k < 11; k++) begin
         kill_slot(0, 1'b0);
      end
      chk("t6_full_score", 32'(score_o), 32'hF);
      kill_slot(1, 1'b0);
      chk("t6_sat_kill",  32'(kill_o),  32'h1);
      chk("t6_sat_score", 32'(score_o), 32'hF);
      kill_slot(7, 1'b1);
      chk("t6_clr_kill",  32'(kill_o),  32'h1);
      chk("t6_clr_score", 32'(score_o), 32'h0);
      kill_slot(8, 1'b0);
      chk("t6_after_clr", 32'(score_o), 32'h1);

      // Asynchronous reset mid-explosion
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_expl", 32'(exploding_o), 32'h0);
      chk("rst_mid_disp", 32'(disappear_o), 32'h0);
      chk("rst_mid_score", 32'(score_o), 32'h0);
      @(posedge clk_run);
      #1;
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("rst_tick%0d_disp", k), 32'(disappear_o), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
